tx_fsm: RTL

TX_FSM -- requirements
Module: tx_fsm

---
 rtl/tx_fsm_if.sv | 24 ++
 rtl/tx_fsm.sv | 107 ++++++++++
 2 files changed

// File: rtl/tx_fsm_if.sv
// Handshake bundle between the local core, tx_fsm and the far-clock receiver.
// master: the tx_fsm side; slave: the core/receiver side driving v, data_in and ack.
interface tx_fsm_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  v;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ack;
  logic                  ready;
  logic                  req;
  logic [DATA_WIDTH-1:0] output_tx;
  logic                  done;
  logic [15:0]           xfer_cnt;

  modport master (
    input  v, data_in, ack,
    output ready, req, output_tx, done, xfer_cnt
  );

  modport slave (
    output v, data_in, ack,
    input  ready, req, output_tx, done, xfer_cnt
  );
endinterface

// File: rtl/tx_fsm.sv
// 4-phase request/acknowledge transmitter towards a far-clock receiver,
// with a synchronized ack and a one-entry pending buffer for back-to-back words.
module tx_fsm #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  tx_fsm_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    pend_full_q, pend_full_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    accept;
  logic                    done;

  assign ack_s  = sync_q[SYNC_STAGES-1];
  // ready depends only on flops, so accept never loops back through ready.
  assign accept = bus.v && !pend_full_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Pending is always empty here; ack_s changes are ignored.
        if (accept) begin
          out_d   = bus.data_in;
          req_d   = 1'b1;
          state_d = StReqHi;
        end
      end
      StReqHi: begin
        if (accept) begin
          pend_full_d = 1'b1;
          pend_data_d = bus.data_in;
        end
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          done  = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (pend_full_q) begin
            out_d       = pend_data_q;
            pend_full_d = 1'b0;
            req_d       = 1'b1;
            state_d     = StReqHi;
          end else if (accept) begin
            out_d   = bus.data_in;
            req_d   = 1'b1;
            state_d = StReqHi;
          end else begin
            state_d = StIdle;
          end
        end else if (accept) begin
          pend_full_d = 1'b1;
          pend_data_d = bus.data_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.ack};
    end
  end

  assign bus.ready     = !pend_full_q;
  assign bus.req       = req_q;
  assign bus.output_tx = out_q;
  assign bus.done      = done;
  assign bus.xfer_cnt  = cnt_q;

endmodule
